// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shared_reg_arbiter
// Purpose  : Round-robin arbiter and write sequencer for one shared WIDTH-bit
//            register. One requester at a time is granted. Its data is loaded
//            one cycle after the grant, and the commit is acknowledged with a
//            one-cycle pulse.
// Ports    : clk     - clock, all state updates on the rising edge
//            CLR     - synchronous active-high reset
//            req     - per-requester level write request
//            wr_data - requester i data at [i*WIDTH +: WIDTH]
//            grant   - registered one-hot grant
//            ack     - one-cycle pulse, granted write committed
//            ack_id  - index of the requester whose write committed
//            busy    - high while the sequencer is not idle
//            Q / Qp  - shared register contents and their complement
// Revision : 1.0 - initial release
// ============================================================================
module shared_reg_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  CLR,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] wr_data,
   output logic [NREQ-1:0]       grant,
   output logic                  ack,
   output logic [IDW-1:0]        ack_id,
   output logic                  busy,
   output logic [WIDTH-1:0]      Q,
   output logic [WIDTH-1:0]      Qp
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_ACK   = 2'd2
   } state_t;

   localparam logic [NREQ-1:0] C_ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
   localparam logic [IDW-1:0]  C_LAST_RST = IDW'(NREQ - 1);

   state_t            r_state,  w_state_next;
   logic [NREQ-1:0]   r_grant,  w_grant_next;
   logic              r_ack,    w_ack_next;
   logic [IDW-1:0]    r_ack_id, w_ack_id_next;
   logic [IDW-1:0]    r_last,   w_last_next;
   logic [IDW-1:0]    r_winner, w_winner_next;
   logic [WIDTH-1:0]  r_q,      w_q_next;

   logic              w_found;
   logic [IDW-1:0]    w_pick;

   // Round-robin search: scan last+1, last+2, ... (mod NREQ) and keep the
   // first requester found. The pointer itself has lowest priority.
   always_comb begin
      logic [IDW-1:0] idx;
      w_found = 1'b0;
      w_pick  = r_last;
      idx     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(r_last) + k) % NREQ);
         if (!w_found && req[idx]) begin
            w_found = 1'b1;
            w_pick  = idx;
         end
      end
   end

   // Next-state and next-output logic; every register holds by default.
   always_comb begin
      w_state_next  = r_state;
      w_grant_next  = r_grant;
      w_ack_next    = r_ack;
      w_ack_id_next = r_ack_id;
      w_last_next   = r_last;
      w_winner_next = r_winner;
      w_q_next      = r_q;

      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_grant_next  = C_ONE_HOT0 << w_pick;
               w_winner_next = w_pick;
               w_state_next  = S_GRANT;
            end
         end
         S_GRANT: begin
            w_grant_next = '0;
            // The winner must still be requesting for the write to commit;
            // otherwise the grant is withdrawn and the pointer stays put.
            if (req[r_winner]) begin
               w_q_next      = wr_data[int'(r_winner)*WIDTH +: WIDTH];
               w_ack_next    = 1'b1;
               w_ack_id_next = r_winner;
               w_last_next   = r_winner;
               w_state_next  = S_ACK;
            end else begin
               w_state_next  = S_IDLE;
            end
         end
         S_ACK: begin
            w_ack_next   = 1'b0;
            w_state_next = S_IDLE;
         end
         default: begin
            w_grant_next = '0;
            w_ack_next   = 1'b0;
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (CLR) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_ack    <= 1'b0;
         r_ack_id <= '0;
         r_last   <= C_LAST_RST;
         r_winner <= '0;
         r_q      <= '0;
      end else begin
         r_state  <= w_state_next;
         r_grant  <= w_grant_next;
         r_ack    <= w_ack_next;
         r_ack_id <= w_ack_id_next;
         r_last   <= w_last_next;
         r_winner <= w_winner_next;
         r_q      <= w_q_next;
      end
   end

   assign grant  = r_grant;
   assign ack    = r_ack;
   assign ack_id = r_ack_id;
   assign busy   = (r_state != S_IDLE);
   assign Q      = r_q;
   assign Qp     = ~r_q;

endmodule
`default_nettype wire
